// File: rtl/mc_ctrl_fsm_v2.sv
// Multi-cycle MIPS control unit: main sequencing FSM, ALU decode, memory handshake
// with a wait watchdog, and illegal-instruction trapping.
module mc_ctrl_fsm_v2 #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ALU_CTRL_W     = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  branch,
    output logic                  branch_ne,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  IorD,
    output logic                  ir_write,
    output logic                  alu_src_A,
    output logic [1:0]            alu_src_B,
    output logic                  imm_zext,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic                  mem_timeout,
    output logic [3:0]            state_dbg
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

    localparam bit                WD_ON   = (TIMEOUT_CYCLES > 0);
    localparam int                CNT_W   = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WRITE = 4'd4,
        S_MEM_WB    = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_IMM_WB    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    waiting;
    logic                    timeout;
    logic                    funct_ok;
    logic [ALU_CTRL_W-1:0]   funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // The watchdog fires only after CNT_MAX unanswered cycles; mem_ready in the same cycle wins.
    assign waiting = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout = WD_ON && waiting && !mem_ready && (wait_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            if (WD_ON && waiting && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            case (state)
                S_FETCH:     if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:             state <= S_MEM_ADR;
                        OP_R:                     state <= funct_ok ? S_EXEC : S_TRAP;
                        OP_BEQ, OP_BNE:           state <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI: state <= S_IMM_EXEC;
                        OP_J:                     state <= S_JUMP;
                        default:                  state <= S_TRAP;
                    endcase
                end
                S_MEM_ADR:   state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (mem_ready)    state <= S_MEM_WB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEM_WRITE: if (mem_ready || timeout) state <= S_FETCH;
                S_EXEC:      state <= S_ALU_WB;
                S_IMM_EXEC:  state <= S_IMM_WB;
                default:     state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'b00;
        branch        = 1'b0;
        branch_ne     = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        IorD          = 1'b0;
        ir_write      = 1'b0;
        alu_src_A     = 1'b0;
        alu_src_B     = 2'b00;
        imm_zext      = 1'b0;
        alu_control   = ALU_AND;
        illegal_instr = 1'b0;
        mem_timeout   = timeout;
        case (state)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_B   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            S_DECODE: begin
                alu_src_B   = 2'b11;
                alu_control = ALU_ADD;
            end
            S_MEM_ADR: begin
                alu_src_A   = 1'b1;
                alu_src_B   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = !timeout;
                IorD      = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_EXEC: begin
                alu_src_A   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_A   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = (opcode == OP_BEQ);
                branch_ne   = (opcode == OP_BNE);
            end
            S_IMM_EXEC, S_IMM_WB: begin
                // IR is stable for the whole instruction, so IMM_WB re-decodes the same controls.
                alu_src_A   = (state == S_IMM_EXEC);
                alu_src_B   = (state == S_IMM_EXEC) ? 2'b10 : 2'b00;
                reg_write   = (state == S_IMM_WB);
                imm_zext    = (opcode == OP_ANDI) || (opcode == OP_ORI);
                alu_control = (opcode == OP_ANDI) ? ALU_AND :
                              (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            S_TRAP:  illegal_instr = 1'b1;
            default: ;
        endcase
        if (!rstn) begin
            mem_req       = 1'b0;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            branch        = 1'b0;
            branch_ne     = 1'b0;
            illegal_instr = 1'b0;
            mem_timeout   = 1'b0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mc_ctrl_fsm_v2.sv
// Directed bench for mc_ctrl_fsm_v2: instruction walks, memory waits, trap,
// watchdog expiry (TIMEOUT_CYCLES=4) and asynchronous reset mid-access.
module tb_mc_ctrl_fsm_v2;

    localparam int T_OUT = 4;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2,
                           S_MEM_READ = 4'd3, S_MEM_WRITE = 4'd4, S_MEM_WB = 4'd5,
                           S_EXEC = 4'd6, S_ALU_WB = 4'd7, S_BRANCH = 4'd8,
                           S_IMM_EXEC = 4'd9, S_IMM_WB = 4'd10, S_JUMP = 4'd11,
                           S_TRAP = 4'd12;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       mem_req, pc_write, branch, branch_ne, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, IorD, ir_write, alu_src_A, imm_zext;
    logic       illegal_instr, mem_timeout;
    logic [1:0] pc_src, alu_src_B;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    mc_ctrl_fsm_v2 #(.TIMEOUT_CYCLES(T_OUT), .ALU_CTRL_W(3)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_write(pc_write), .pc_src(pc_src), .branch(branch),
        .branch_ne(branch_ne), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .IorD(IorD), .ir_write(ir_write),
        .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .imm_zext(imm_zext),
        .alu_control(alu_control), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp);
        check(tag, 32'(state_dbg), 32'(exp));
    endtask

    // Start an instruction from FETCH with memory answering immediately.
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        #1;
        chk_state("fetch_state", S_FETCH);
        tick();
        chk_state("decode_state", S_DECODE);
        tick();
    endtask

    initial begin
        rstn      = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        mem_ready = 1'b0;
        tick();
        tick();
        chk_state("rst_state", S_FETCH);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_pc_write", 32'(pc_write), 0);
        rstn = 1'b1;

        // ADD R-type with ready memory
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        #1;
        chk_state("add_fetch", S_FETCH);
        check("add_fetch_req", 32'(mem_req), 1);
        check("add_fetch_irw", 32'(ir_write), 1);
        check("add_fetch_pcw", 32'(pc_write), 1);
        check("add_fetch_srcb", 32'(alu_src_B), 1);
        check("add_fetch_alu", 32'(alu_control), 32'h2);
        tick();
        chk_state("add_decode", S_DECODE);
        check("add_decode_srcb", 32'(alu_src_B), 3);
        tick();
        chk_state("add_exec", S_EXEC);
        check("add_exec_alu", 32'(alu_control), 32'h2);
        check("add_exec_srca", 32'(alu_src_A), 1);
        check("add_exec_rw", 32'(reg_write), 0);
        tick();
        chk_state("add_alu_wb", S_ALU_WB);
        check("add_wb_rw", 32'(reg_write), 1);
        check("add_wb_dst", 32'(reg_dst), 1);
        tick();
        chk_state("add_done", S_FETCH);
        check("add_done_rw", 32'(reg_write), 0);

        // SUB and SLT decode in EXEC
        fetch_decode(6'b000000, 6'b100010);
        check("sub_exec_alu", 32'(alu_control), 32'h6);
        tick(); tick();
        fetch_decode(6'b000000, 6'b101010);
        check("slt_exec_alu", 32'(alu_control), 32'h7);
        tick(); tick();

        // LW with three wait cycles in MEM_READ
        fetch_decode(6'b100011, 6'd0);
        chk_state("lw_mem_adr", S_MEM_ADR);
        check("lw_adr_srcb", 32'(alu_src_B), 2);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk_state("lw_wait_state", S_MEM_READ);
            check("lw_wait_req", 32'(mem_req), 1);
            check("lw_wait_iord", 32'(IorD), 1);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_state("lw_ready_state", S_MEM_READ);
        check("lw_ready_req", 32'(mem_req), 1);
        check("lw_ready_tmo", 32'(mem_timeout), 0);
        tick();
        chk_state("lw_mem_wb", S_MEM_WB);
        check("lw_wb_rw", 32'(reg_write), 1);
        check("lw_wb_m2r", 32'(mem_to_reg), 1);
        check("lw_wb_dst", 32'(reg_dst), 0);
        tick();
        chk_state("lw_done", S_FETCH);

        // ORI
        fetch_decode(6'b001101, 6'd0);
        chk_state("ori_exec", S_IMM_EXEC);
        check("ori_exec_zext", 32'(imm_zext), 1);
        check("ori_exec_alu", 32'(alu_control), 32'h1);
        check("ori_exec_srcb", 32'(alu_src_B), 2);
        tick();
        chk_state("ori_wb", S_IMM_WB);
        check("ori_wb_zext", 32'(imm_zext), 1);
        check("ori_wb_alu", 32'(alu_control), 32'h1);
        check("ori_wb_rw", 32'(reg_write), 1);
        check("ori_wb_m2r", 32'(mem_to_reg), 0);
        tick();

        // ADDI sign-extends
        fetch_decode(6'b001000, 6'd0);
        check("addi_zext", 32'(imm_zext), 0);
        check("addi_alu", 32'(alu_control), 32'h2);
        tick(); tick();

        // BNE
        fetch_decode(6'b000101, 6'd0);
        chk_state("bne_branch", S_BRANCH);
        check("bne_ne", 32'(branch_ne), 1);
        check("bne_eq", 32'(branch), 0);
        check("bne_pcsrc", 32'(pc_src), 1);
        check("bne_alu", 32'(alu_control), 32'h6);
        tick();
        chk_state("bne_done", S_FETCH);

        // BEQ
        fetch_decode(6'b000100, 6'd0);
        check("beq_eq", 32'(branch), 1);
        check("beq_ne", 32'(branch_ne), 0);
        tick();

        // J
        fetch_decode(6'b000010, 6'd0);
        chk_state("j_jump", S_JUMP);
        check("j_pcsrc", 32'(pc_src), 2);
        check("j_pcw", 32'(pc_write), 1);
        tick();
        chk_state("j_done", S_FETCH);

        // Illegal opcode and illegal funct
        fetch_decode(6'b111111, 6'd0);
        chk_state("ill_op_trap", S_TRAP);
        check("ill_op_pulse", 32'(illegal_instr), 1);
        check("ill_op_rw", 32'(reg_write), 0);
        check("ill_op_mw", 32'(mem_write), 0);
        check("ill_op_pcw", 32'(pc_write), 0);
        tick();
        chk_state("ill_op_done", S_FETCH);
        check("ill_op_pulse_end", 32'(illegal_instr), 0);
        fetch_decode(6'b000000, 6'b000000);
        chk_state("ill_fn_trap", S_TRAP);
        check("ill_fn_pulse", 32'(illegal_instr), 1);
        tick();

        // SW with memory stuck: watchdog abandons after T_OUT waits
        fetch_decode(6'b101011, 6'd0);
        chk_state("sw_mem_adr", S_MEM_ADR);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < T_OUT; i++) begin
            chk_state("sw_wait_state", S_MEM_WRITE);
            check("sw_wait_mw", 32'(mem_write), 1);
            check("sw_wait_tmo", 32'(mem_timeout), 0);
            tick();
        end
        chk_state("sw_tmo_state", S_MEM_WRITE);
        check("sw_tmo_pulse", 32'(mem_timeout), 1);
        check("sw_tmo_mw", 32'(mem_write), 0);
        tick();
        chk_state("sw_tmo_fetch", S_FETCH);
        check("sw_tmo_end", 32'(mem_timeout), 0);

        // FETCH retries in place after its own timeout
        for (int i = 1; i < T_OUT; i++) begin
            tick();
            check("fetch_wait_tmo", 32'(mem_timeout), 0);
        end
        tick();
        check("fetch_tmo_pulse", 32'(mem_timeout), 1);
        check("fetch_tmo_irw", 32'(ir_write), 0);
        tick();
        chk_state("fetch_retry", S_FETCH);
        check("fetch_retry_tmo", 32'(mem_timeout), 0);

        // Asynchronous reset in the middle of a store
        fetch_decode(6'b101011, 6'd0);
        mem_ready = 1'b0;
        tick();
        chk_state("rst_sw_state", S_MEM_WRITE);
        check("rst_sw_req_pre", 32'(mem_req), 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_sw_req", 32'(mem_req), 0);
        check("rst_sw_mw", 32'(mem_write), 0);
        chk_state("rst_sw_fetch", S_FETCH);
        #2 rstn = 1'b1;
        tick();
        chk_state("rst_release", S_FETCH);
        check("rst_release_req", 32'(mem_req), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
